// File: rtl/ttl74x595_sipo_if.sv
// Signal bundle for the 74x595-style SIPO receiver.
// Carries TTL74X595_PARITY_EN's PAR line when that macro is defined.
interface ttl74x595_sipo_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          DS;
  logic          SH_EN;
  logic          ST;
  logic          SCLR_n;
  logic          OE_n;
  logic [WIDTH-1:0] Q;
  logic          QH_S;
  logic [CW-1:0] CNT;
  logic          FULL;
  logic          OVR;
`ifdef TTL74X595_PARITY_EN
  logic          PAR;
`endif

  modport master (
    output DS, SH_EN, ST, SCLR_n, OE_n,
`ifdef TTL74X595_PARITY_EN
    input  PAR,
`endif
    input  Q, QH_S, CNT, FULL, OVR
  );

  modport slave (
    input  DS, SH_EN, ST, SCLR_n, OE_n,
`ifdef TTL74X595_PARITY_EN
    output PAR,
`endif
    output Q, QH_S, CNT, FULL, OVR
  );
endinterface

// File: rtl/ttl74x595_sipo.sv
// Shift register plus storage latch with bit count and overflow.
// Optional TTL74X595_PARITY_EN adds PAR = XOR of storage.
module ttl74x595_sipo #(
  parameter int WIDTH = 8
) (
  input logic CLK,
  input logic MR_n,
  ttl74x595_sipo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_st;
  logic [CW-1:0]    r_cnt;
  logic             r_ovr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_full;

  assign w_sr_nxt = {r_sr[WIDTH-2:0], bus.DS};
  assign w_full   = (r_cnt == W_CNT);

  // Shift register, bit counter and sticky overflow.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else if (!bus.SCLR_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (bus.SH_EN) r_sr <= w_sr_nxt;
      if (bus.ST) begin
        r_cnt <= bus.SH_EN ? CW'(1) : '0;
        r_ovr <= 1'b0;
      end else if (bus.SH_EN) begin
        if (w_full) r_ovr <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Storage latch takes the pre-edge shift value; clear leaves it.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_st <= '0;
    end else if (bus.SCLR_n && bus.ST) begin
      r_st <= r_sr;
    end
  end

`ifdef TTL74X595_PARITY_EN
  logic r_par;

  // Parity captured alongside storage on the store edge.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_par <= 1'b0;
    end else if (bus.SCLR_n && bus.ST) begin
      r_par <= ^r_sr;
    end
  end

  assign bus.PAR = bus.OE_n ? 1'b0 : r_par;
`endif

  assign bus.Q    = bus.OE_n ? '0 : r_st;
  assign bus.QH_S = r_sr[WIDTH-1];
  assign bus.CNT  = r_cnt;
  assign bus.FULL = w_full;
  assign bus.OVR  = r_ovr;
endmodule

// File: tb/tb_ttl74x595_sipo.sv
// Directed bench for ttl74x595_sipo, WIDTH=8.
// Checks PAR too when TTL74X595_PARITY_EN is defined.
module tb_ttl74x595_sipo;
  logic CLK = 1'b0;
  logic MR_n;
  int n_cmp = 0;
  int n_bad = 0;

  ttl74x595_sipo_if #(.WIDTH(8)) bus ();

  ttl74x595_sipo #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .MR_n (MR_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.DS = 1'b0;
    bus.SH_EN = 1'b0;
    bus.ST = 1'b0;
    bus.SCLR_n = 1'b1;
  endtask

  task automatic edge_drv(logic ds, logic sh, logic st, logic sclr_n);
    @(negedge CLK);
    bus.DS = ds;
    bus.SH_EN = sh;
    bus.ST = st;
    bus.SCLR_n = sclr_n;
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic shift_byte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) edge_drv(v[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic store();
    edge_drv(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_flags(string tag, int cnt, logic full, logic ovr);
    check({tag, ".cnt"}, 32'(bus.CNT), 32'(cnt));
    check({tag, ".full"}, 32'(bus.FULL), 32'(full));
    check({tag, ".ovr"}, 32'(bus.OVR), 32'(ovr));
  endtask

  initial begin
    logic [8:0] bits9;
    MR_n = 1'b0;
    bus.OE_n = 1'b0;
    idle();

    // 1: reset holds everything low while inputs toggle
    for (int k = 0; k < 4; k++) begin
      bus.DS = 1'($urandom);
      bus.SH_EN = 1'($urandom);
      bus.ST = 1'($urandom);
      bus.SCLR_n = 1'($urandom);
      #3;
      check("rst.q", 32'(bus.Q), 0);
      check("rst.qh", 32'(bus.QH_S), 0);
      check_flags("rst", 0, 1'b0, 1'b0);
    end
    @(negedge CLK);
    idle();
    MR_n = 1'b1;

    // 2: shift 0xA5, then store
    for (int i = 7; i >= 1; i--) edge_drv(8'hA5 >> i, 1'b1, 1'b0, 1'b1);
    check_flags("a5.s7", 7, 1'b0, 1'b0);
    edge_drv(1'b1, 1'b1, 1'b0, 1'b1);
    check_flags("a5.s8", 8, 1'b1, 1'b0);
    check("a5.qh", 32'(bus.QH_S), 1);
    check("a5.q_pre", 32'(bus.Q), 0);
    store();
    check("a5.q", 32'(bus.Q), 32'h A5);
    check_flags("a5.st", 0, 1'b0, 1'b0);
`ifdef TTL74X595_PARITY_EN
    check("a5.par", 32'(bus.PAR), 0);
`endif

    // 3: simultaneous store and shift at full count
    shift_byte(8'h3C);
    check_flags("3c.full", 8, 1'b1, 1'b0);
    edge_drv(1'b1, 1'b1, 1'b1, 1'b1);
    check("3c.q", 32'(bus.Q), 32'h3C);
    check_flags("3c.both", 1, 1'b0, 1'b0);
    check("3c.qh", 32'(bus.QH_S), 0);
    store();
    check("79.q", 32'(bus.Q), 32'h79);
    check("79.cnt", 32'(bus.CNT), 0);
`ifdef TTL74X595_PARITY_EN
    check("79.par", 32'(bus.PAR), 1);
`endif

    // 4: ninth shift overflows and drops the oldest bit
    bits9 = 9'b1_0000_0001;
    for (int i = 8; i >= 1; i--) edge_drv(bits9[i], 1'b1, 1'b0, 1'b1);
    check_flags("ovr.s8", 8, 1'b1, 1'b0);
    check("ovr.qh8", 32'(bus.QH_S), 1);
    edge_drv(bits9[0], 1'b1, 1'b0, 1'b1);
    check_flags("ovr.s9", 8, 1'b1, 1'b1);
    check("ovr.qh9", 32'(bus.QH_S), 0);
    store();
    check("ovr.q", 32'(bus.Q), 32'h01);
    check_flags("ovr.st", 0, 1'b0, 1'b0);

    // 5: output enable and synchronous clear
    shift_byte(8'h5A);
    store();
    check("5a.q", 32'(bus.Q), 32'h5A);
    bus.OE_n = 1'b1;
    #1;
    check("5a.oe_off", 32'(bus.Q), 0);
`ifdef TTL74X595_PARITY_EN
    check("5a.par_off", 32'(bus.PAR), 0);
`endif
    for (int i = 0; i < 3; i++) edge_drv(1'b1, 1'b1, 1'b0, 1'b1);
    check("5a.cnt3", 32'(bus.CNT), 3);
    edge_drv(1'b1, 1'b1, 1'b1, 1'b0);
    check_flags("5a.clr", 0, 1'b0, 1'b0);
    check("5a.clr_qh", 32'(bus.QH_S), 0);
    bus.OE_n = 1'b0;
    #1;
    check("5a.kept", 32'(bus.Q), 32'h5A);
    store();
    check("5a.sr0", 32'(bus.Q), 0);

    // 6: async reset mid-frame
    shift_byte(8'h77);
    store();
    for (int i = 0; i < 4; i++) edge_drv(1'b1, 1'b1, 1'b0, 1'b1);
    check("mr.cnt4", 32'(bus.CNT), 4);
    @(negedge CLK);
    #2;
    MR_n = 1'b0;
    #1;
    check("mr.q", 32'(bus.Q), 0);
    check("mr.qh", 32'(bus.QH_S), 0);
    check_flags("mr", 0, 1'b0, 1'b0);
    @(negedge CLK);
    MR_n = 1'b1;
    edge_drv(1'b1, 1'b1, 1'b0, 1'b1);
    check("mr.cnt1", 32'(bus.CNT), 1);
    store();
    check("mr.sr", 32'(bus.Q), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
